// File: rtl/cnn_ctrl_pkg.sv
// Package: cnn_ctrl_pkg
// Shared definitions for the CNN PE controller: state encoding width and the
// FSM state enumeration used by cnn_pe_controller.
package cnn_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FIND   = 4'd1,
    S_CHECK  = 4'd2,
    S_READ   = 4'd3,
    S_MULT   = 4'd4,
    S_ACC    = 4'd5,
    S_WRITE  = 4'd6,
    S_WAIT   = 4'd7,
    S_NFILT  = 4'd8,
    S_RETIRE = 4'd9,
    S_ERROR  = 4'd10
  } state_t;

endpackage

// File: rtl/cnn_ctrl_perf_counters.sv
// Module: cnn_ctrl_perf_counters
// Saturating performance counters for the CNN PE controller. Present only when
// CNN_CTRL_PERF_EN is defined.
// Ports:
//   clk, rst      clock / synchronous active-high clear
//   stall_hold    FSM is holding in S_CHECK or S_WAIT this cycle
//   mac_step      FSM is in S_ACC this cycle
//   stall_cycles  count of held cycles, saturates at all-ones
//   mac_count     count of accumulate cycles, saturates at all-ones
`ifdef CNN_CTRL_PERF_EN
module cnn_ctrl_perf_counters #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_hold,
  input  logic             mac_step,
  output logic [WIDTH-1:0] stall_cycles,
  output logic [WIDTH-1:0] mac_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      mac_count    <= '0;
    end else begin
      if (stall_hold && (stall_cycles != '1)) stall_cycles <= stall_cycles + WIDTH'(1);
      if (mac_step && (mac_count != '1))      mac_count    <= mac_count + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/cnn_pe_controller.sv
// Module: cnn_pe_controller
// FSM sequencing one CNN PE datapath: finds the next IFmap window, runs the
// read/multiply/accumulate loop per filter tap, hands results to the result
// buffer, steps strides and filters, and retires consumed IFmap rows.
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   start                         begin processing (sampled in S_IDLE only)
//   sp_valid, error               start_ptr valid / error_detector
//   filter_cannot_read, reading_empty   hold in S_CHECK while either is high
//   go_next_stride, stride_ended, is_last_filter   loop-exit conditions
//   stall[1:0]                    write buffer busy, nonzero holds S_WAIT
//   datapath strobes / local clears  one-hot-ish control outputs
//   busy                          FSM active (not idle, not errored)
//   err_flag                      sticky error indication, cleared by rst
// Optional feature macro: CNN_CTRL_PERF_EN adds stall_cycles / mac_count
// outputs (width PERF_CNT_WIDTH).
module cnn_pe_controller
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned PERF_CNT_WIDTH = 16
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sp_valid,
  input  logic       error,
  input  logic       filter_cannot_read,
  input  logic       reading_empty,
  input  logic       go_next_stride,
  input  logic       stride_ended,
  input  logic       is_last_filter,
  input  logic [1:0] stall,
  output logic       en_p_traverse,
  output logic       ren,
  output logic       ld_IF,
  output logic       mult_en,
  output logic       i_en,
  output logic       ld_result,
  output logic       en_f_counter,
  output logic       done,
  output logic       next_stride,
  output logic       next_filter,
  output logic       next_start,
  output logic       make_empty,
  output logic       rst_result,
  output logic       rst_stride,
  output logic       rst_stride_ended,
  output logic       rst_current_filter,
  output logic       rst_is_last_filter,
  output logic       rst_p_valid,
  output logic       rst_f_counter,
  output logic       busy,
  output logic       err_flag
`ifdef CNN_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] mac_count
`endif
);

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FIND;
      S_FIND: begin
        if (error)         state_nxt = S_ERROR;
        else if (sp_valid) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (error)                                    state_nxt = S_ERROR;
        else if (!(filter_cannot_read || reading_empty)) state_nxt = S_READ;
      end
      S_READ:   state_nxt = S_MULT;
      S_MULT:   state_nxt = S_ACC;
      S_ACC:    state_nxt = go_next_stride ? S_WRITE : S_CHECK;
      S_WRITE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (stall == 2'b00) begin
          if (!stride_ended)       state_nxt = S_CHECK;
          else if (!is_last_filter) state_nxt = S_NFILT;
          else                     state_nxt = S_RETIRE;
        end
      end
      S_NFILT:  state_nxt = S_CHECK;
      S_RETIRE: state_nxt = S_FIND;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes are masked while rst is high so nothing fires in the cycle the
  // reset is being applied, whatever state is still registered.
  always_comb begin
    en_p_traverse      = 1'b0;
    ren                = 1'b0;
    ld_IF              = 1'b0;
    mult_en            = 1'b0;
    i_en               = 1'b0;
    ld_result          = 1'b0;
    en_f_counter       = 1'b0;
    done               = 1'b0;
    next_stride        = 1'b0;
    next_filter        = 1'b0;
    next_start         = 1'b0;
    make_empty         = 1'b0;
    rst_result         = 1'b0;
    rst_stride         = 1'b0;
    rst_stride_ended   = 1'b0;
    rst_current_filter = 1'b0;
    rst_is_last_filter = 1'b0;
    rst_p_valid        = 1'b0;
    rst_f_counter      = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  rst_f_counter = 1'b1;
        S_FIND:  en_p_traverse = 1'b1;
        S_READ: begin
          ren   = 1'b1;
          ld_IF = 1'b1;
        end
        S_MULT:  mult_en = 1'b1;
        S_ACC: begin
          ld_result    = 1'b1;
          i_en         = 1'b1;
          en_f_counter = 1'b1;
        end
        S_WRITE: done = 1'b1;
        S_WAIT: begin
          if (stall == 2'b00) begin
            rst_result  = 1'b1;
            next_stride = !stride_ended;
          end
        end
        S_NFILT: begin
          next_filter      = 1'b1;
          rst_stride       = 1'b1;
          rst_stride_ended = 1'b1;
        end
        S_RETIRE: begin
          make_empty         = 1'b1;
          next_start         = 1'b1;
          rst_p_valid        = 1'b1;
          rst_current_filter = 1'b1;
          rst_is_last_filter = 1'b1;
          rst_stride         = 1'b1;
          rst_stride_ended   = 1'b1;
          rst_f_counter      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE) && (state != S_ERROR);
  // S_ERROR is only left through rst, so the state decode is itself sticky.
  assign err_flag = (state == S_ERROR);

`ifdef CNN_CTRL_PERF_EN
  logic stall_hold;

  assign stall_hold = !rst &&
                      (((state == S_CHECK) && !error && (filter_cannot_read || reading_empty)) ||
                       ((state == S_WAIT) && (stall != 2'b00)));

  cnn_ctrl_perf_counters #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_hold   (stall_hold),
    .mac_step     (state == S_ACC),
    .stall_cycles (stall_cycles),
    .mac_count    (mac_count)
  );
`endif

endmodule
